// File: rtl/nonogram_pkg.sv
// Shared sizing, types and FSM encoding for the nonogram board-setup logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nonogram_pkg;

   localparam int MAX_ROWS  = 11;
   localparam int MAX_COLS  = 11;
   localparam int MAX_LEN   = 11;             // max(MAX_ROWS, MAX_COLS)
   localparam int MAX_CLUES = 6;              // (MAX_LEN+1)/2
   localparam int MAX_OPTS  = 84;             // solver options-table depth
   localparam int OPT_W     = 16;
   localparam int IDX_W     = 5;              // $clog2(MAX_ROWS+MAX_COLS)
   localparam int CNT_W     = 7;

   // Count value held while the beat that reaches MAX_OPTS is on the bus.
   localparam logic [CNT_W-1:0] OPTS_LAST = CNT_W'(MAX_OPTS - 1);
   localparam logic [CNT_W-1:0] OPTS_MAX  = CNT_W'(MAX_OPTS);

   typedef logic [OPT_W-1:0] option_t;
   typedef logic [3:0]       clue_t;
   typedef logic [3:0]       pos_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_EMIT = 2'd2,
      ST_FIN  = 2'd3
   } og_state_e;

endpackage

// File: rtl/optgen_render.sv
// Renders block start positions + clue lengths into a cell mask (bit i = cell i filled).
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
// Ports: pos_i / clue_i per block, num_clues_i active block count, mask_o rendered option
//        (bits >= MAX_LEN always 0).
module optgen_render
   import nonogram_pkg::*;
(
   input  pos_t  [MAX_CLUES-1:0] pos_i,
   input  clue_t [MAX_CLUES-1:0] clue_i,
   input  logic  [2:0]           num_clues_i,
   output option_t               mask_o
);

   always_comb begin
      mask_o = '0;
      for (int k = 0; k < MAX_CLUES; k++) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            if ((3'(k) < num_clues_i) &&
                (5'(i) >= {1'b0, pos_i[k]}) &&
                (5'(i) <  ({1'b0, pos_i[k]} + {1'b0, clue_i[k]}))) begin
               mask_o[i] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/line_option_gen.sv
// Enumerates every legal fill pattern of one nonogram line and streams them as option beats.
// Latency: start -> first beat 2 cycles; then one option per cycle while opt_ready is high.
// Backpressure: opt_data/opt_line/opt_last hold until opt_valid && opt_ready.
// Ports: clk/rst (sync, active-high); start + line_idx/line_len/num_clues/clues/known/assigned
//        request; opt_valid/opt_ready/opt_data/opt_line/opt_last option stream; busy, done,
//        opt_count, infeasible, overflow status.
// Build option: OPTGEN_PRUNE_EN skips candidates that contradict known/assigned cells.
module line_option_gen
   import nonogram_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [IDX_W-1:0]        line_idx,
   input  logic [3:0]              line_len,
   input  logic [2:0]              num_clues,
   input  clue_t [MAX_CLUES-1:0]   clues,
   input  logic [MAX_LEN-1:0]      known,
   input  logic [MAX_LEN-1:0]      assigned,
   output logic                    busy,
   output logic                    opt_valid,
   input  logic                    opt_ready,
   output option_t                 opt_data,
   output logic [IDX_W-1:0]        opt_line,
   output logic                    opt_last,
   output logic                    done,
   output logic [CNT_W-1:0]        opt_count,
   output logic                    infeasible,
   output logic                    overflow
);

   og_state_e                state_q, state_d;
   logic [3:0]               len_q, len_d;
   logic [2:0]               n_q, n_d;
   clue_t [MAX_CLUES-1:0]    clue_q, clue_d;
   pos_t  [MAX_CLUES-1:0]    pos_q, pos_d;
   logic [IDX_W-1:0]         line_q, line_d;
   logic [CNT_W-1:0]         count_q, count_d;
   logic                     inf_q, inf_d;
   logic                     ovf_q, ovf_d;

   logic [MAX_CLUES-1:0]     act;
   logic [7:0]               lp [MAX_CLUES];
   logic [7:0]               need;
   logic                     fits;
   pos_t  [MAX_CLUES-1:0]    load_pos;
   logic [4:0]               pos_ext [MAX_CLUES+1];
   logic [MAX_CLUES-1:0]     mov;
   logic [2:0]               sel;
   logic                     found;
   pos_t  [MAX_CLUES-1:0]    adv_pos;
   option_t                  cand_mask;
   logic                     last_cand;
   logic                     pruned;
   logic                     xfer;

`ifdef OPTGEN_PRUNE_EN
   logic [MAX_LEN-1:0]       known_q, known_d;
   logic [MAX_LEN-1:0]       asg_q, asg_d;

   assign pruned = (state_q == ST_EMIT) &&
                   (|((cand_mask[MAX_LEN-1:0] ^ asg_q) & known_q));
`else
   logic                     prune_unused;

   assign prune_unused = ^{known, assigned};
   assign pruned       = 1'b0;
`endif

   // Block k takes part only when k < num_clues.
   always_comb begin
      for (int k = 0; k < MAX_CLUES; k++) begin
         act[k] = (3'(k) < n_q);
      end
   end

   // Left-packed placement and fit test, in 8 bits so oversized clue lists cannot wrap.
   always_comb begin
      lp[0] = '0;
      for (int k = 1; k < MAX_CLUES; k++) begin
         lp[k] = lp[k-1] + {4'b0, clue_q[k-1]} + 8'd1;
      end
      need = '0;
      for (int k = 0; k < MAX_CLUES; k++) begin
         if (act[k]) need = lp[k] + {4'b0, clue_q[k]};
      end
      fits = (need <= {4'b0, len_q});
      for (int k = 0; k < MAX_CLUES; k++) begin
         load_pos[k] = act[k] ? lp[k][3:0] : '0;
      end
   end

   // Movable blocks: one more cell to the right must still leave a gap before the next
   // block (or stay inside the line for the last block). The highest movable one advances.
   always_comb begin
      for (int k = 0; k < MAX_CLUES; k++) begin
         pos_ext[k] = {1'b0, pos_q[k]};
      end
      pos_ext[MAX_CLUES] = '0;
      mov   = '0;
      sel   = '0;
      found = 1'b0;
      for (int k = 0; k < MAX_CLUES; k++) begin
         if (act[k]) begin
            if ((3'(k) + 3'd1) == n_q) begin
               mov[k] = (({1'b0, pos_q[k]} + {1'b0, clue_q[k]}) < {1'b0, len_q});
            end else begin
               mov[k] = (({1'b0, pos_q[k]} + {1'b0, clue_q[k]} + 5'd1) < pos_ext[k+1]);
            end
         end
         if (mov[k]) begin
            sel   = 3'(k);
            found = 1'b1;
         end
      end
      last_cand = !found;

      adv_pos = pos_q;
      for (int j = 0; j < MAX_CLUES; j++) begin
         if (found && (3'(j) == sel)) adv_pos[j] = pos_q[j] + 4'd1;
      end
      // Blocks right of the moved one re-pack tightly behind it.
      for (int j = 1; j < MAX_CLUES; j++) begin
         if (found && (3'(j) > sel)) adv_pos[j] = adv_pos[j-1] + clue_q[j-1] + 4'd1;
      end
   end

   optgen_render u_render (
      .pos_i       (pos_q),
      .clue_i      (clue_q),
      .num_clues_i (n_q),
      .mask_o      (cand_mask)
   );

   assign xfer = opt_valid && opt_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      n_d     = n_q;
      clue_d  = clue_q;
      pos_d   = pos_q;
      line_d  = line_q;
      count_d = count_q;
      inf_d   = inf_q;
      ovf_d   = ovf_q;
`ifdef OPTGEN_PRUNE_EN
      known_d = known_q;
      asg_d   = asg_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD;
               len_d   = line_len;
               n_d     = num_clues;
               clue_d  = clues;
               line_d  = line_idx;
               count_d = '0;
               inf_d   = 1'b0;
               ovf_d   = 1'b0;
`ifdef OPTGEN_PRUNE_EN
               known_d = known;
               asg_d   = assigned;
`endif
            end
         end
         ST_LOAD: begin
            if (!fits) begin
               inf_d   = 1'b1;
               state_d = ST_FIN;
            end else begin
               pos_d   = load_pos;
               state_d = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (xfer) begin
               if (count_q != OPTS_MAX) count_d = count_q + 7'd1;
               if (count_q == OPTS_LAST) begin
                  ovf_d   = 1'b1;
                  state_d = ST_FIN;
               end else if (last_cand) begin
                  state_d = ST_FIN;
               end else begin
                  pos_d = adv_pos;
               end
            end else if (pruned) begin
               if (last_cand) begin
                  state_d = ST_FIN;
                  if (count_q == '0) inf_d = 1'b1;
               end else begin
                  pos_d = adv_pos;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         len_q   <= '0;
         n_q     <= '0;
         clue_q  <= '0;
         pos_q   <= '0;
         line_q  <= '0;
         count_q <= '0;
         inf_q   <= 1'b0;
         ovf_q   <= 1'b0;
`ifdef OPTGEN_PRUNE_EN
         known_q <= '0;
         asg_q   <= '0;
`endif
      end else begin
         len_q   <= len_d;
         n_q     <= n_d;
         clue_q  <= clue_d;
         pos_q   <= pos_d;
         line_q  <= line_d;
         count_q <= count_d;
         inf_q   <= inf_d;
         ovf_q   <= ovf_d;
`ifdef OPTGEN_PRUNE_EN
         known_q <= known_d;
         asg_q   <= asg_d;
`endif
      end
   end

   // Outputs.
   always_comb begin
      busy       = (state_q == ST_LOAD) || (state_q == ST_EMIT);
      opt_valid  = (state_q == ST_EMIT) && !pruned;
      opt_data   = opt_valid ? cand_mask : '0;
      opt_line   = line_q;
      opt_last   = opt_valid && (last_cand || (count_q == OPTS_LAST));
      done       = (state_q == ST_FIN);
      opt_count  = count_q;
      infeasible = inf_q;
      overflow   = ovf_q;
   end

endmodule

// File: tb/tb_line_option_gen.sv
// Directed bench for line_option_gen: table of clue lists with expected option streams,
// plus hand-written stall, start-while-busy and reset sequences.
module tb_line_option_gen;
   import nonogram_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start;
   logic [IDX_W-1:0]      line_idx;
   logic [3:0]            line_len;
   logic [2:0]            num_clues;
   logic [5:0][3:0]       clues;
   logic [MAX_LEN-1:0]    known;
   logic [MAX_LEN-1:0]    assigned;
   logic                  busy;
   logic                  opt_valid;
   logic                  opt_ready;
   option_t               opt_data;
   logic [IDX_W-1:0]      opt_line;
   logic                  opt_last;
   logic                  done;
   logic [CNT_W-1:0]      opt_count;
   logic                  infeasible;
   logic                  overflow;

   always #5 clk = ~clk;

   line_option_gen dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .line_idx   (line_idx),
      .line_len   (line_len),
      .num_clues  (num_clues),
      .clues      (clues),
      .known      (known),
      .assigned   (assigned),
      .busy       (busy),
      .opt_valid  (opt_valid),
      .opt_ready  (opt_ready),
      .opt_data   (opt_data),
      .opt_line   (opt_line),
      .opt_last   (opt_last),
      .done       (done),
      .opt_count  (opt_count),
      .infeasible (infeasible),
      .overflow   (overflow)
   );

   typedef struct {
      int               idx;
      int               len;
      int               n;
      logic [5:0][3:0]  cl;
      int               nb;     // expected beat count
      logic [10:0][15:0] exp;   // first (up to 11) expected masks
      int               inf;
      int               ovf;
   } vec_t;

   int   tests = 0;
   int   fails = 0;
   vec_t tbl [10];

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input int idx, input int len, input int n,
                               input int c0, input int c1, input int c2,
                               input int nb, input int inf, input int ovf);
      vec_t v;
      v.idx = idx; v.len = len; v.n = n; v.nb = nb; v.inf = inf; v.ovf = ovf;
      v.cl = '0;
      v.cl[0] = 4'(c0); v.cl[1] = 4'(c1); v.cl[2] = 4'(c2);
      v.exp = '0;
      return v;
   endfunction

   task automatic apply_start(input vec_t v);
      line_idx  = 5'(v.idx);
      line_len  = 4'(v.len);
      num_clues = 3'(v.n);
      clues     = v.cl;
      start     = 1'b1;
   endtask

   // Runs one line; optional stall of stall_len cycles on beat stall_at; optional
   // extra start pulse while busy (must be dropped).
   task automatic run_vec(input vec_t v, input int stall_at, input int stall_len, input bit poke);
      int beats   = 0;
      int stalled = 0;
      bit poked   = 1'b0;
      bit fin     = 1'b0;
      @(negedge clk);
      opt_ready = 1'b1;
      apply_start(v);
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", int'(busy), 1);
      for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            chk("done_count", int'(opt_count), v.nb);
            chk("done_beats", beats, v.nb);
            chk("done_infeasible", int'(infeasible), v.inf);
            chk("done_overflow", int'(overflow), v.ovf);
            chk("done_busy_low", int'(busy), 0);
            fin = 1'b1;
         end else if (opt_valid) begin
            if (beats == stall_at && stalled < stall_len) begin
               opt_ready = 1'b0;
               stalled++;
               chk("stall_held_data", int'(opt_data), int'(v.exp[beats]));
               chk("stall_held_last", int'(opt_last), 0);
            end else begin
               opt_ready = 1'b1;
               if (beats < 11) chk("beat_data", int'(opt_data), int'(v.exp[beats]));
               chk("beat_line", int'(opt_line), v.idx);
               chk("beat_last", int'(opt_last), int'(beats == v.nb - 1));
               beats++;
            end
            if (poke && !poked && beats == 2) begin
               line_idx  = 5'd7;
               line_len  = 4'd4;
               num_clues = 3'd1;
               start     = 1'b1;
               poked     = 1'b1;
            end
         end
      end
      if (!fin) chk("line_timeout", 0, 1);
      opt_ready = 1'b1;
   endtask

   initial begin
      vec_t v;
      bit   seen;

      // len=5 {2,1}
      v = mk(3, 5, 2, 2, 1, 0, 3, 0, 0);
      v.exp[0] = 16'h00B; v.exp[1] = 16'h013; v.exp[2] = 16'h016;
      tbl[0] = v;
      // len=11 {1}: single cell walks across the line
      v = mk(21, 11, 1, 1, 0, 0, 11, 0, 0);
      for (int j = 0; j < 11; j++) v.exp[j] = 16'(1 << j);
      tbl[1] = v;
      // len=3 {2,2}: does not fit
      tbl[2] = mk(4, 3, 2, 2, 2, 0, 0, 1, 0);
      // len=4, no clues: one empty option
      tbl[3] = mk(9, 4, 0, 0, 0, 0, 1, 0, 0);
      // len=4 {3}
      v = mk(1, 4, 1, 3, 0, 0, 2, 0, 0);
      v.exp[0] = 16'h007; v.exp[1] = 16'h00E;
      tbl[4] = v;
      // len=11 {11}: full line
      v = mk(12, 11, 1, 11, 0, 0, 1, 0, 0);
      v.exp[0] = 16'h7FF;
      tbl[5] = v;
      // len=6 {1,2}
      v = mk(6, 6, 2, 1, 2, 0, 6, 0, 0);
      v.exp[0] = 16'h00D; v.exp[1] = 16'h019; v.exp[2] = 16'h031;
      v.exp[3] = 16'h01A; v.exp[4] = 16'h032; v.exp[5] = 16'h034;
      tbl[6] = v;
      // len=1 {1}
      v = mk(0, 1, 1, 1, 0, 0, 1, 0, 0);
      v.exp[0] = 16'h001;
      tbl[7] = v;
      // len=11 {5,5}: exactly fits
      v = mk(17, 11, 2, 5, 5, 0, 1, 0, 0);
      v.exp[0] = 16'h7DF;
      tbl[8] = v;
      // len=11 {1,1,1}: C(9,3)=84 options, reaches the saturation limit
      v = mk(30, 11, 3, 1, 1, 1, 84, 0, 1);
      v.exp[0]  = 16'h015; v.exp[1]  = 16'h025; v.exp[2]  = 16'h045;
      v.exp[3]  = 16'h085; v.exp[4]  = 16'h105; v.exp[5]  = 16'h205;
      v.exp[6]  = 16'h405; v.exp[7]  = 16'h029; v.exp[8]  = 16'h049;
      v.exp[9]  = 16'h089; v.exp[10] = 16'h109;
      tbl[9] = v;

      rst = 1'b1; start = 1'b0; opt_ready = 1'b1;
      line_idx = '0; line_len = '0; num_clues = '0; clues = '0;
      known = '0; assigned = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(opt_valid), 0);
      chk("rst_data", int'(opt_data), 0);
      chk("rst_line", int'(opt_line), 0);
      chk("rst_last", int'(opt_last), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_count", int'(opt_count), 0);
      chk("rst_infeasible", int'(infeasible), 0);
      chk("rst_overflow", int'(overflow), 0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) run_vec(tbl[i], -1, 0, 1'b0);

      // Backpressure: hold the second beat for 3 cycles.
      run_vec(tbl[0], 1, 3, 1'b0);
      // start pulse while busy must not disturb the running line.
      run_vec(tbl[1], -1, 0, 1'b1);

      // Reset mid-line after the first beat.
      @(negedge clk);
      apply_start(tbl[0]);
      opt_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (opt_valid) seen = 1'b1;
      end
      chk("midrst_first_beat_seen", int'(seen), 1);
      @(negedge clk);
      chk("midrst_second_beat", int'(opt_data), 16'h013);
      chk("midrst_count_before", int'(opt_count), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_valid", int'(opt_valid), 0);
      chk("midrst_data", int'(opt_data), 0);
      chk("midrst_line", int'(opt_line), 0);
      chk("midrst_last", int'(opt_last), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_count", int'(opt_count), 0);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("midrst_no_beats", int'(opt_valid | busy | done), 0);
      end
      run_vec(tbl[4], -1, 0, 1'b0);

      // start together with rst is dropped.
      @(negedge clk);
      apply_start(tbl[0]);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("start_with_rst_busy", int'(busy), 0);
      @(negedge clk);
      chk("start_with_rst_valid", int'(opt_valid | done), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
